// File: rtl/apb_icn_n_if.sv
// apb_icn_n_if: APB bus bundle; N>1 carries per-slave select/ready/error/read-data lanes.
interface apb_icn_n_if #(parameter int AW = 20, parameter int DW = 16, parameter int N = 1);
  logic [N-1:0]    psel;
  logic            penable;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic            pwrite;
  logic [DW/8-1:0] pstrb;
  logic [N*DW-1:0] prdata;
  logic [N-1:0]    pready;
  logic [N-1:0]    pslverr;
  modport master (output psel, penable, paddr, pwdata, pwrite, pstrb, input prdata, pready, pslverr);
  modport slave  (input psel, penable, paddr, pwdata, pwrite, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_icn_n.sv
// apb_icn_n: APB 1-to-NUM_SLV interconnect with address decode, decode-error slave and wait-state watchdog.
module apb_icn_n #(
  parameter int NUM_SLV = 2,
  parameter int AW      = 20,
  parameter int DW      = 16,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  apb_icn_n_if.slave  m,
  apb_icn_n_if.master s,
  output logic        decerr_evt,
  output logic        tout_evt
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DECERR = 2'd2;
  logic [1:0]      state;
  logic [IDXW-1:0] idx, idx_q;
  logic [CW-1:0]   cnt;
  logic            hit, setup, act, rdy, err, tout;
  logic [DW-1:0]   rd;
  assign idx   = m.paddr[AW-1 -: IDXW];
  assign hit   = 32'(idx) < NUM_SLV;
  assign setup = state == IDLE && m.psel[0] && !m.penable;
  assign act   = state == ACCESS && m.psel[0];
  always_comb begin
    rdy = 1'b0;
    err = 1'b0;
    rd  = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (32'(idx_q) == i) begin
        rdy = s.pready[i];
        err = s.pslverr[i];
        rd  = s.prdata[i*DW +: DW];
      end
  end
  // watchdog fires on the cycle the count would reach TIMEOUT; a ready slave still wins
  assign tout       = act && TIMEOUT > 0 && !rdy && 32'(cnt) == TIMEOUT - 1;
  assign tout_evt   = tout;
  assign decerr_evt = state == DECERR && m.psel[0] && m.penable;
  assign s.psel     = setup && hit ? NUM_SLV'(1) << idx : act && !tout ? NUM_SLV'(1) << idx_q : '0;
  assign s.penable  = act && !tout && m.penable;
  assign s.paddr    = m.paddr;
  assign s.pwdata   = m.pwdata;
  assign s.pwrite   = m.pwrite;
  assign s.pstrb    = m.pstrb;
  assign m.pready   = act && (rdy || tout) || decerr_evt;
  assign m.pslverr  = act && (rdy ? err : tout) || decerr_evt;
  assign m.prdata   = act && rdy && !m.pwrite ? rd : '0;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
    end else if (setup) begin
      idx_q <= idx;
      cnt   <= '0;
      state <= hit ? ACCESS : DECERR;
    end else if (state == ACCESS) begin
      if (!m.psel[0] || rdy || tout) begin
        state <= IDLE;
        cnt   <= '0;
      end else cnt <= &cnt ? cnt : cnt + 1'b1;
    end else if (state == DECERR && (!m.psel[0] || m.penable)) state <= IDLE;
  end
endmodule

// File: doc/apb_icn_n.md
Name: apb_icn_n

Overview:
- Synthesizable, parametrised APB interconnect: one APB master port fanned out to NUM_SLV slave ports.
- Decodes the upper address bits to pick a slave and muxes the selected slave's prdata/pready/pslverr back to the master.
- A default slave answers unmapped addresses with an error.
- A per-transfer wait-state watchdog aborts hung slaves.
- Replaces the fixed 2-slave testbench ICN model in the SPI/crypto subsystem bus.

Parameters:
- NUM_SLV, 2, number of slave ports (1..8).
- AW, 20, APB address width.
- DW, 16, APB data width; pstrb width is DW/8.
- IDXW, 3, number of top address bits used as the slave index, paddr[AW-1:AW-IDXW]; must satisfy 2**IDXW >= NUM_SLV.
- TIMEOUT, 16, maximum ACCESS-phase cycles without pready; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- psel  in  1  master select
- penable  in  1  master enable
- paddr  in  AW  master address
- pwdata  in  DW  master write data
- pwrite  in  1  master write flag
- pstrb  in  DW/8  master byte strobes
- prdata  out  DW  read data to master
- pready  out  1  ready to master
- pslverr  out  1  error to master
- psel_s  out  NUM_SLV  one-hot slave selects
- penable_s  out  1  enable to slaves (shared)
- paddr_s  out  AW  address to slaves (paddr passed through)
- pwdata_s  out  DW  pass-through
- pwrite_s  out  1  pass-through
- pstrb_s  out  DW/8  pass-through
- prdata_s  in  NUM_SLV*DW  slave read data; slave i occupies bits [i*DW +: DW]
- pready_s  in  NUM_SLV  slave ready
- pslverr_s  in  NUM_SLV  slave error
- decerr_evt  out  1  one-cycle pulse when a decode error completes
- tout_evt  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE; wait counter and latched index are cleared.
  - All outputs are 0 while in IDLE with psel=0: psel_s=0, penable_s=0, prdata=0, pready=0, pslverr=0, both event pulses 0.
- Reset asserted mid-transfer: the transfer is dropped with no response.
- States:
  - IDLE: no transfer. psel=1 and penable=0 → SETUP actions:
    - Decode idx = paddr[AW-1:AW-IDXW] and latch it in idx_q.
    - Set hit = (idx < NUM_SLV).
    - psel_s[idx] is asserted combinationally in this same cycle only when hit=1.
    - Next state: ACCESS if hit, DECERR if not.
  - ACCESS:
    - psel_s[idx_q]=1 and penable_s=penable.
    - prdata, pready and pslverr come combinationally from slave idx_q.
    - Wait counter increments each cycle in which pready_s[idx_q]=0.
    - pready_s[idx_q]=1 → counter cleared; next state IDLE, or SETUP handling if the master immediately starts a back-to-back transfer.
    - Counter reaches TIMEOUT (TIMEOUT>0) with the slave still not ready:
      - That cycle pready=1, pslverr=1, prdata=0, psel_s=0, penable_s=0.
      - tout_evt=1 for one cycle; next state IDLE.
  - DECERR:
    - psel_s=0 throughout.
    - In the first penable=1 cycle, drive pready=1, pslverr=1, prdata=0 and decerr_evt=1; next state IDLE. Zero wait states.
- Pass-through signals (paddr_s, pwdata_s, pwrite_s, pstrb_s) are always combinational copies of the master inputs.
- Unselected slaves never see psel_s=1.
- prdata is valid only when pready=1 and pwrite=0; otherwise prdata=0.
- Protocol violation (master drops psel during ACCESS or DECERR): return to IDLE, no response, no event pulse.
- Counter width is clog2(TIMEOUT+1); saturating, never wraps.
- Slave pslverr_s is passed through unchanged on the completion cycle.
- Pready from the slave and the watchdog firing in the same cycle: the slave wins (normal completion, no tout_evt).

Test Plan:
- Write to slave 1 (AW=20, IDXW=3): paddr=20'h20010, pwdata=16'h1234, slave pready after 2 wait cycles → psel_s=2'b10, pwdata_s=16'h1234, master pready=1 with pslverr=0 in the 3rd ACCESS cycle.
- Read from slave 0 at paddr=20'h00004, prdata_s slice 0 = 16'hABCD, pready_s[0]=1 immediately → prdata=16'hABCD, zero wait states.
- Unmapped address paddr=20'hE0000 (idx=7) → psel_s=0, pready=1, pslverr=1, prdata=0, decerr_evt one pulse.
- Slave 0 holds pready_s=0 forever with TIMEOUT=16 → pready=1, pslverr=1 in ACCESS cycle 16, tout_evt pulse, psel_s drops the same cycle.
- Slave pslverr passthrough: pslverr_s[1]=1 with pready_s[1]=1 → pslverr=1, tout_evt=0; then a back-to-back transfer to slave 0 completes normally.
- Reset during an ACCESS with 5 wait states elapsed → next cycle all outputs 0; a fresh transfer afterwards times out only after the full 16 cycles.
